// File: rtl/piso_pkg.sv
// Shared types and default sizes for the tapped parallel-in / serial-out serializer.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int PISO_WIDTH_DEF = 8;
    localparam int PISO_DEPTH_DEF = 4;

endpackage

// File: rtl/piso_beat_cnt.sv
// Beat counter for one parallel load: clears on load, counts output handshakes,
// and flags the terminal beat (DEPTH-1). It saturates there instead of wrapping.
module piso_beat_cnt
    import piso_pkg::*;
#(
    parameter  int DEPTH = PISO_DEPTH_DEF,
    localparam int CW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && !tc) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/piso_tap_serializer.sv
// Loads DEPTH words in parallel and emits them word 0 first over a valid/ready port.
// Optional out_last (final word marker) is built only when PISO_LAST_EN is defined.
module piso_tap_serializer
    import piso_pkg::*;
#(
    parameter  int WIDTH = PISO_WIDTH_DEF,
    parameter  int DEPTH = PISO_DEPTH_DEF,
    localparam int CW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [WIDTH*DEPTH-1:0] load_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
`ifdef PISO_LAST_EN
    output logic                   out_last,
`endif
    output state_t                 fsm_state,
    output logic [CW-1:0]          beat_count
);

    // Handshakes: a transfer happens in a cycle where valid && ready are both 1 at
    // the rising edge. A source holds valid and its payload until that cycle; ready
    // may depend combinationally on the other side (load_ready follows out_ready).

    state_t                 state_q;
    state_t                 state_d;
    logic [WIDTH*DEPTH-1:0] data_q;
    logic                   tc;
    logic                   final_beat;
    logic                   load_acc;
    logic                   out_hs;

    assign final_beat = (state_q == SHIFT) && tc && out_ready;
    assign load_acc   = load_valid && load_ready;
    assign out_hs     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_acc) state_d = SHIFT;
            SHIFT:   if (final_beat && !load_acc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_ready = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
                load_ready = final_beat;
                out_valid  = 1'b1;
                out_data   = data_q[WIDTH-1:0];
            end
            default: begin
                load_ready = 1'b0;
            end
        endcase
    end

`ifdef PISO_LAST_EN
    assign out_last = out_valid && tc;
`endif

    // A load on the final beat overrides the shift so the next word 0 follows with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (load_acc) begin
            data_q <= load_data;
        end else if (out_hs) begin
            data_q <= {{WIDTH{1'b0}}, data_q[WIDTH*DEPTH-1:WIDTH]};
        end
    end

    piso_beat_cnt #(
        .DEPTH(DEPTH)
    ) u_beat_cnt (
        .clk  (clk),
        .rst  (rst),
        .clear(load_acc),
        .inc  (out_hs),
        .count(beat_count),
        .tc   (tc)
    );

    assign fsm_state = state_q;

endmodule

// File: tb/tb_piso_tap_serializer.sv
// Bench for piso_tap_serializer (WIDTH=8, DEPTH=4): directed vector table, then
// random traffic against a word-queue reference model. Checks out_last under PISO_LAST_EN.
module tb_piso_tap_serializer;
    import piso_pkg::*;

    localparam int W = 8;
    localparam int D = 4;
    localparam logic [31:0] WA = 32'h4433_2211;
    localparam logic [31:0] WB = 32'h8877_6655;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic         load_ready;
    logic [W*D-1:0] load_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    state_t       fsm_state;
    logic [1:0]   beat_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    piso_tap_serializer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef PISO_LAST_EN
        .out_last  (out_last),
`endif
        .fsm_state (fsm_state),
        .beat_count(beat_count)
    );

`ifndef PISO_LAST_EN
    assign out_last = 1'b0;
`endif

    typedef struct {
        logic        r;
        logic        lv;
        logic [31:0] ld;
        logic        ordy;
        logic        ov;
        logic [7:0]  od;
        logic        lr;
        logic        last;
    } vec_t;

    vec_t vecs[$];
    logic [W-1:0] exp_q[$];

    function automatic void add(input logic r, lv, input logic [31:0] ld, input logic ordy,
                                input logic ov, input logic [7:0] od, input logic lr, last);
        vec_t v;
        v.r = r; v.lv = lv; v.ld = ld; v.ordy = ordy;
        v.ov = ov; v.od = od; v.lr = lr; v.last = last;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, lv, input logic [31:0] ld, input logic ordy);
        @(negedge clk);
        rst = r; load_valid = lv; load_data = ld; out_ready = ordy;
        #1;
    endtask

    task automatic check_outs(input string tag, input logic ov, input logic [7:0] od,
                              input logic lr, input logic last);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        check({tag, ".out_data"}, 32'(out_data), 32'(od));
        check({tag, ".load_ready"}, 32'(load_ready), 32'(lr));
`ifdef PISO_LAST_EN
        check({tag, ".out_last"}, 32'(out_last), 32'(last));
`endif
    endtask

    initial begin
        logic m_ov, m_lr, m_last, acc;
        logic [7:0] m_od;

        rst = 1'b1; load_valid = 1'b0; load_data = '0; out_ready = 1'b0;

        // Idle after reset
        add(0,0,0,1, 0,8'h00,1,0);
        add(0,0,0,1, 0,8'h00,1,0);
        // Single load, free-running sink
        add(0,1,WA,1, 0,8'h00,1,0);
        add(0,0,0,1, 1,8'h11,0,0);
        add(0,0,0,1, 1,8'h22,0,0);
        add(0,0,0,1, 1,8'h33,0,0);
        add(0,0,0,1, 1,8'h44,1,1);
        add(0,0,0,1, 0,8'h00,1,0);
        // Stall three cycles on the first word
        add(0,1,WA,1, 0,8'h00,1,0);
        add(0,0,0,0, 1,8'h11,0,0);
        add(0,0,0,0, 1,8'h11,0,0);
        add(0,0,0,0, 1,8'h11,0,0);
        add(0,0,0,1, 1,8'h11,0,0);
        add(0,0,0,1, 1,8'h22,0,0);
        add(0,0,0,1, 1,8'h33,0,0);
        add(0,0,0,1, 1,8'h44,1,1);
        add(0,0,0,1, 0,8'h00,1,0);
        // Back-to-back loads; second load held until the final beat
        add(0,1,WA,1, 0,8'h00,1,0);
        add(0,1,WB,1, 1,8'h11,0,0);
        add(0,1,WB,1, 1,8'h22,0,0);
        add(0,1,WB,1, 1,8'h33,0,0);
        add(0,1,WB,1, 1,8'h44,1,1);
        add(0,0,0,1, 1,8'h55,0,0);
        add(0,0,0,1, 1,8'h66,0,0);
        add(0,0,0,1, 1,8'h77,0,0);
        add(0,0,0,1, 1,8'h88,1,1);
        add(0,0,0,1, 0,8'h00,1,0);
        // Reset after the second word, with load and handshake also active
        add(0,1,WA,1, 0,8'h00,1,0);
        add(0,0,0,1, 1,8'h11,0,0);
        add(0,0,0,1, 1,8'h22,0,0);
        add(1,1,WB,1, 1,8'h33,0,0);
        add(0,0,0,1, 0,8'h00,1,0);
        add(0,0,0,1, 0,8'h00,1,0);
        // Reset wins over a load accept from idle
        add(1,1,WA,1, 0,8'h00,1,0);
        add(0,0,0,1, 0,8'h00,1,0);
        // Load pulsed mid-sequence is ignored
        add(0,1,WA,1, 0,8'h00,1,0);
        add(0,0,0,1, 1,8'h11,0,0);
        add(0,1,WB,1, 1,8'h22,0,0);
        add(0,0,0,1, 1,8'h33,0,0);
        add(0,0,0,1, 1,8'h44,1,1);
        add(0,0,0,1, 0,8'h00,1,0);
        // Stall on the last word, then reload on the final beat
        add(0,1,WA,1, 0,8'h00,1,0);
        add(0,0,0,1, 1,8'h11,0,0);
        add(0,0,0,1, 1,8'h22,0,0);
        add(0,0,0,1, 1,8'h33,0,0);
        add(0,0,0,0, 1,8'h44,0,1);
        add(0,1,WB,0, 1,8'h44,0,1);
        add(0,1,WB,1, 1,8'h44,1,1);
        add(0,0,0,1, 1,8'h55,0,0);
        add(0,0,0,1, 1,8'h66,0,0);
        add(0,0,0,1, 1,8'h77,0,0);
        add(0,0,0,1, 1,8'h88,1,1);
        add(0,0,0,1, 0,8'h00,1,0);

        // Reset and first cycle after it
        apply(1, 0, 0, 0);
        apply(1, 1, WA, 1);
        apply(0, 0, 0, 1);
        check_outs("reset", 1'b0, 8'h00, 1'b1, 1'b0);
        check("reset.fsm_state", 32'(fsm_state), 32'(IDLE));
        check("reset.beat_count", 32'(beat_count), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].r, vecs[i].lv, vecs[i].ld, vecs[i].ordy);
            check_outs($sformatf("vec%0d", i), vecs[i].ov, vecs[i].od, vecs[i].lr, vecs[i].last);
        end

        // Random traffic against a queue of words still owed to the sink
        apply(1, 0, 0, 0);
        exp_q.delete();
        for (int c = 0; c < 500; c++) begin
            apply(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), $urandom,
                  ($urandom_range(0, 3) != 0));
            m_ov   = (exp_q.size() > 0);
            m_od   = m_ov ? exp_q[0] : 8'h00;
            m_lr   = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
            m_last = (exp_q.size() == 1);
            check_outs($sformatf("rand%0d", c), m_ov, m_od, m_lr, m_last);
            if (rst) begin
                exp_q.delete();
            end else begin
                acc = load_valid && m_lr;
                if (m_ov && out_ready) void'(exp_q.pop_front());
                if (acc) begin
                    for (int k = 0; k < D; k++) exp_q.push_back(load_data[k*W +: W]);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/piso_tap_serializer.md
PISO_TAP_SERIALIZER -- requirements
Module: piso_tap_serializer

Interface
REQ-001 Parameter WIDTH, default 8, bits per word.
REQ-002 Parameter DEPTH, default 4, words per parallel load; legal range 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 load_valid  input  1  parallel load request.
REQ-006 load_ready  output  1  block can accept a load this cycle.
REQ-007 load_data  input  WIDTH*DEPTH  word k at bits [k*WIDTH +: WIDTH].
REQ-008 out_valid  output  1  out_data holds a valid word.
REQ-009 out_ready  input  1  downstream accepts the word.
REQ-010 out_data  output  WIDTH  current serial word.
REQ-011 out_last  output  1  final word of a load; present only with PISO_LAST_EN (REQ-030).

Function
REQ-012 States IDLE and SHIFT; the state type lives in the package (REQ-032).
REQ-013 IDLE: load_ready=1, out_valid=0, out_data=0.
REQ-014 Load accept = load_valid && load_ready; it captures all DEPTH words, sets beat count to 0, and enters SHIFT.
REQ-015 Latency: word 0 appears on out_data with out_valid=1 in the cycle after load accept.
REQ-016 Output order: word 0, then word 1, through word DEPTH-1; one word per output handshake (out_valid && out_ready).
REQ-017 On each output handshake, the register shifts down one word, zero-fills the top word, and increments the beat count.
REQ-018 While out_valid=1 and out_ready=0: out_data, out_valid and the beat count hold stable.
REQ-019 Beat count width is $clog2(DEPTH); the count never exceeds DEPTH-1 and never wraps inside one load.
REQ-020 Final beat = SHIFT && count==DEPTH-1 && out_ready.
REQ-021 load_ready=1 in SHIFT only during the final beat (combinational from out_ready); it is 0 otherwise.
REQ-022 Final beat with no load accept: return to IDLE next cycle, with out_valid=0.
REQ-023 Final beat with a simultaneous load accept: capture the new words, reset the count to 0, and stay in SHIFT. New word 0 is valid the next cycle, with no bubble.
REQ-024 A load_valid asserted in SHIFT outside the final beat is not accepted; the upstream holds it.
REQ-025 Sustained throughput with out_ready=1 and load_valid=1: one word per cycle, indefinitely.

Reset
REQ-026 While rst=1 at a clock edge: state becomes IDLE, count 0, data register all zeros.
REQ-027 First cycle after reset: out_valid=0, out_data=0, load_ready=1, out_last=0.
REQ-028 Reset mid-SHIFT discards the remaining words; no further output handshake completes until a new load.
REQ-029 rst takes priority over simultaneous load and output handshakes.

Configuration
REQ-030 Macro PISO_LAST_EN defined: port out_last exists and equals 1 exactly when out_valid=1 and count==DEPTH-1; otherwise 0.
REQ-031 Macro PISO_LAST_EN undefined: port out_last and its logic are absent; all other behaviour is identical.

Structure
REQ-032 Shared package piso_pkg holds the state typedef (IDLE, SHIFT) and the default constants PISO_WIDTH_DEF=8 and PISO_DEPTH_DEF=4.
REQ-033 Sub-module piso_beat_cnt holds the beat counter: clear, increment and terminal-count flag at DEPTH-1, parameterised by DEPTH.
REQ-034 Datapath, FSM and handshake logic stay in piso_tap_serializer.

Verification (WIDTH=8, DEPTH=4)
REQ-035 Reset then idle -> out_valid=0, load_ready=1, out_data=0x00.
REQ-036 Load 0x44_33_22_11 with out_ready=1 -> out_data 0x11,0x22,0x33,0x44 on cycles 1-4; out_last=1 on 0x44 only; IDLE on cycle 5.
REQ-037 Same load, out_ready=0 for 3 cycles after the first word -> 0x11 held stable 3 cycles, then the sequence resumes; the total is still 4 words.
REQ-038 Back-to-back loads 0x44332211 then 0x88776655, load_valid and out_ready held 1 -> 8 consecutive words 0x11..0x88 with no idle cycle.
REQ-039 rst=1 after the second word (0x22) -> next cycle out_valid=0 and load_ready=1; words 0x33 and 0x44 are never emitted.
REQ-040 load_valid pulsed during the second word with out_ready=1 -> not accepted (load_ready=0); the current 4-word sequence completes unchanged.
